// File: rtl/pe_wacc_multilane.sv
// Weighted-accumulation PE for the NLM denoise datapath: LANES weight/pixel pairs per beat,
// three-stage pipeline (products, lane reduction, accumulate), packet result held until consumed.
//
// state | meaning
// ACCUM | accepting beats; in_ready=1
// DRAIN | last beat accepted; pipeline flushing into accumulators; in_ready=0
// HOLD  | packet result valid; waiting for out_ready
module pe_wacc_multilane #(
  parameter int DATA_WIDTH   = 16,
  parameter int WEIGHT_WIDTH = 8,
  parameter int LANES        = 4,
  parameter int ACC_WIDTH    = 32,
  parameter int CNT_WIDTH    = 8,
  parameter int SATURATE     = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clear_i,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_last,
  input  logic [LANES*WEIGHT_WIDTH-1:0]   weight_i,
  input  logic [LANES*DATA_WIDTH-1:0]     pix_i,
  input  logic [LANES-1:0]                lane_mask_i,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [ACC_WIDTH-1:0]            pix_sum_o,
  output logic [ACC_WIDTH-1:0]            weight_sum_o,
  output logic [CNT_WIDTH-1:0]            beat_cnt_o,
  output logic                            ovf_o
);

  localparam int PW  = DATA_WIDTH + WEIGHT_WIDTH;
  localparam int LW  = $clog2(LANES);
  localparam int SPW = PW + LW;
  localparam int SWW = WEIGHT_WIDTH + LW;

  typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

  state_t                  state;
  logic                    accept;
  logic                    s1_valid, s1_last, s2_valid, s2_last;
  logic [PW-1:0]           s1_prod [LANES];
  logic [WEIGHT_WIDTH-1:0] s1_wt   [LANES];
  logic [SPW-1:0]          s2_pix;
  logic [SWW-1:0]          s2_wt;
  logic [SPW-1:0]          red_pix;
  logic [SWW-1:0]          red_wt;
  logic [ACC_WIDTH:0]      sum_pix, sum_wt;
  logic [ACC_WIDTH-1:0]    nxt_pix, nxt_wt;

  // Clear discards any beat presented in the same cycle.
  assign accept = in_valid & in_ready & ~clear_i;

  always_comb begin
    red_pix = '0;
    red_wt  = '0;
    for (int k = 0; k < LANES; k++) begin
      red_pix = red_pix + SPW'(s1_prod[k]);
      red_wt  = red_wt  + SWW'(s1_wt[k]);
    end
  end

  // One extra bit catches the carry-out for overflow detection.
  always_comb begin
    sum_pix = {1'b0, pix_sum_o}    + (ACC_WIDTH+1)'(s2_pix);
    sum_wt  = {1'b0, weight_sum_o} + (ACC_WIDTH+1)'(s2_wt);
    nxt_pix = (sum_pix[ACC_WIDTH] && SATURATE != 0) ? '1 : sum_pix[ACC_WIDTH-1:0];
    nxt_wt  = (sum_wt[ACC_WIDTH]  && SATURATE != 0) ? '1 : sum_wt[ACC_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LANES; k++) begin
        s1_prod[k] <= '0;
        s1_wt[k]   <= '0;
      end
      s2_pix <= '0;
      s2_wt  <= '0;
    end else begin
      for (int k = 0; k < LANES; k++) begin
        s1_prod[k] <= lane_mask_i[k]
                      ? PW'(weight_i[k*WEIGHT_WIDTH +: WEIGHT_WIDTH]) * PW'(pix_i[k*DATA_WIDTH +: DATA_WIDTH])
                      : '0;
        s1_wt[k]   <= lane_mask_i[k] ? weight_i[k*WEIGHT_WIDTH +: WEIGHT_WIDTH] : '0;
      end
      s2_pix <= red_pix;
      s2_wt  <= red_wt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ACCUM;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      pix_sum_o    <= '0;
      weight_sum_o <= '0;
      beat_cnt_o   <= '0;
      ovf_o        <= 1'b0;
      s1_valid     <= 1'b0;
      s1_last      <= 1'b0;
      s2_valid     <= 1'b0;
      s2_last      <= 1'b0;
    end else if (clear_i) begin
      state        <= ACCUM;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      pix_sum_o    <= '0;
      weight_sum_o <= '0;
      beat_cnt_o   <= '0;
      ovf_o        <= 1'b0;
      s1_valid     <= 1'b0;
      s1_last      <= 1'b0;
      s2_valid     <= 1'b0;
      s2_last      <= 1'b0;
    end else begin
      s1_valid <= accept;
      s1_last  <= accept & in_last;
      s2_valid <= s1_valid;
      s2_last  <= s1_valid & s1_last;

      if (accept && beat_cnt_o != '1)
        beat_cnt_o <= beat_cnt_o + CNT_WIDTH'(1);

      if (s2_valid) begin
        pix_sum_o    <= nxt_pix;
        weight_sum_o <= nxt_wt;
        if (sum_pix[ACC_WIDTH] || sum_wt[ACC_WIDTH])
          ovf_o <= 1'b1;
      end

      case (state)
        ACCUM: begin
          if (accept && in_last) begin
            state    <= DRAIN;
            in_ready <= 1'b0;
          end
        end
        DRAIN: begin
          if (s2_valid && s2_last) begin
            state     <= HOLD;
            out_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state        <= ACCUM;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            pix_sum_o    <= '0;
            weight_sum_o <= '0;
            beat_cnt_o   <= '0;
            ovf_o        <= 1'b0;
          end
        end
        default: begin
          state    <= ACCUM;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/pe_wacc_multilane.md
Name: pe_wacc_multilane

Overview:
- Next-generation weighted-accumulation PE for the RAW denoise (NLM-style) datapath.
- Accepts LANES weight/search-pixel pairs per beat under a valid/ready handshake.
- Accumulates sum(weight*pixel) and sum(weight) across a packet delimited by in_last, then holds the packet result under an output valid/ready handshake.
- Adds lane masking, selectable saturating accumulation, a sticky overflow flag, a beat counter and a synchronous clear.

Parameters:
- DATA_WIDTH, 16: unsigned search-pixel width.
- WEIGHT_WIDTH, 8: unsigned weight width.
- LANES, 4: pairs per beat; must be ≥1.
- ACC_WIDTH, 32: accumulator width; must be ≥ DATA_WIDTH+WEIGHT_WIDTH+clog2(LANES).
- CNT_WIDTH, 8: beat-counter width.
- SATURATE, 1: 1 = clamp accumulators at all-ones; 0 = wrap modulo 2^ACC_WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear_i  in  1  synchronous clear; discards packet and pipeline.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_last  in  1  final beat of packet.
- weight_i  in  LANES*WEIGHT_WIDTH  lane k at bits [k*WEIGHT_WIDTH +: WEIGHT_WIDTH].
- pix_i  in  LANES*DATA_WIDTH  lane k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- lane_mask_i  in  LANES  1 = lane contributes; 0 = lane treated as weight 0 / pixel 0.
- out_valid  out  1  packet result valid.
- out_ready  in  1  consumer accepts result.
- pix_sum_o  out  ACC_WIDTH  accumulated weight*pixel.
- weight_sum_o  out  ACC_WIDTH  accumulated weight.
- beat_cnt_o  out  CNT_WIDTH  beats accepted in the packet; saturates at all-ones.
- ovf_o  out  1  sticky: an accumulator overflowed during this packet.

Behaviour:
- Reset, asynchronous: state ACCUM; in_ready=1; out_valid=0; pix_sum_o=0; weight_sum_o=0; beat_cnt_o=0; ovf_o=0; all pipeline valids 0.
- Accept occurs on an edge where in_valid & in_ready.
- Pipeline:
  - S1 registers per-lane masked products (DATA_WIDTH+WEIGHT_WIDTH bits) and masked weights.
  - S2 registers the lane reductions (+clog2(LANES) bits).
  - S3 adds S2 into the accumulators.
- Latency: last beat accepted at edge n → accumulators final and out_valid=1 after edge n+2.
- Beats accepted at consecutive edges stream at 1 beat/cycle.
- beat_cnt_o increments on each accept (saturating); it is not pipelined.
- States:
  - ACCUM: in_ready=1. Accept with in_last → DRAIN.
  - DRAIN: in_ready=0; lasts 2 cycles while S1/S2 empty. Transitions to HOLD on the edge the last beat enters the accumulators; out_valid is set on that same edge.
  - HOLD: in_ready=0; out_valid=1. pix_sum_o, weight_sum_o, beat_cnt_o and ovf_o are stable. Edge with out_ready=1: accumulators, beat_cnt_o and ovf_o clear to 0, out_valid→0, state→ACCUM. in_ready=1 in the following cycle; no accept on the handshake edge itself.
- in_valid while in_ready=0 is ignored; no data is captured.
- Overflow detection: each accumulator update is computed at ACC_WIDTH+1 bits. If the carry-out is set:
  - SATURATE=1: result = all-ones.
  - SATURATE=0: low ACC_WIDTH bits kept.
  - Either mode: ovf_o is set and stays set until the packet handshake or clear.
  - Each accumulator saturates independently.
- Packets with all lanes masked contribute 0 but still count as beats.
- A packet of exactly one beat (in_last on the first beat) is legal.
- clear_i=1 at an edge, any state: pipeline valids 0, accumulators/beat_cnt_o/ovf_o = 0, out_valid=0, state ACCUM. clear_i has priority over a simultaneous accept or output handshake. An accept in the same cycle as clear_i is discarded.
- rst_n assertion mid-packet or mid-HOLD: immediate return to the reset values; the partial result is lost.

Test Plan (LANES=4, DATA_WIDTH=16, WEIGHT_WIDTH=8, ACC_WIDTH=32 unless stated):
- Single beat, last=1, weights {1,2,3,4}, pix {10,20,30,40}, mask 1111, accepted at edge n → after edge n+2: out_valid=1, pix_sum_o=300, weight_sum_o=10, beat_cnt_o=1, ovf_o=0.
- Three back-to-back beats, weights all 255, pix all 65535, masks 1111/0011/1000, last on beat 3 → weight_sum_o=1785, pix_sum_o=116979975, beat_cnt_o=3; in_ready=0 from the edge after beat 3 until after the output handshake.
- HOLD with out_ready=0 for 5 cycles while in_valid=1 with data → outputs unchanged, nothing accepted. out_ready=1 → next cycle: all sums 0, in_ready=1.
- ACC_WIDTH=26, SATURATE=1, two beats of all-255 weights × all-65535 pixels → pix_sum_o=67108863, ovf_o=1, weight_sum_o=2040. Same stimulus with SATURATE=0 → pix_sum_o=66582536, ovf_o=1.
- clear_i pulsed one cycle after the 2nd of 4 beats, with an accept in the same cycle → out_valid never rises. A following 1-beat packet (weight 1, pix 7, mask 0001) yields pix_sum_o=7, beat_cnt_o=1.
- rst_n asserted low during DRAIN → all outputs at reset values immediately; in_ready=1 after release.
